frame_sync_flag: RTL and testbench

- Upstream control stage for the streaming brightness filter: produces its 2-bit freq_flag gain select.
- Debounces the raw frequency-band strobe from the audio detector.
- Commits a new flag only at a video frame boundary (accepted end-of-packet), so every frame is processed with a single gain setting and no frame tears.
- Passively snoops the 12-bit pixel stream handshake; never drives or stalls the stream.

---
 rtl/frame_sync_flag.sv | 104 ++++++++++
 tb/tb_frame_sync_flag.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_flag.sv
// Debounces the audio band strobe and commits the brightness gain flag only on
// an accepted end-of-packet, so each video frame sees one constant gain.
module frame_sync_flag #(
   parameter int unsigned STABLE_COUNT = 4,
   parameter int unsigned HOLD_FRAMES  = 2,
   parameter logic [1:0]  DEFAULT_FLAG = 2'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] flag_in,
   input  logic       flag_valid,
   input  logic       valid_in,
   input  logic       ready_in,
   input  logic       eop_in,
   output logic [1:0] flag_out,
   output logic       flag_changed,
   output logic       pending
);

   logic [1:0] flag_q, flag_d;
   logic [1:0] cand_q, cand_d;
   logic [3:0] stable_cnt_q, stable_cnt_d;
   logic [1:0] pend_flag_q, pend_flag_d;
   logic       pending_q, pending_d;
   logic [3:0] frames_since_q, frames_since_d;
   logic       changed_q, changed_d;
   logic       eop_acc;
   logic       commit;
   logic       qualified;

   always_comb begin
      flag_d         = flag_q;
      cand_d         = cand_q;
      stable_cnt_d   = stable_cnt_q;
      pend_flag_d    = pend_flag_q;
      pending_d      = pending_q;
      frames_since_d = frames_since_q;
      changed_d      = 1'b0;

      eop_acc = valid_in & ready_in & eop_in;
      commit  = eop_acc && pending_q &&
                ((int'(frames_since_q) + 1) >= int'(HOLD_FRAMES));

      if (eop_acc && frames_since_q != 4'd15) begin
         frames_since_d = frames_since_q + 4'd1;
      end

      // The commit uses the pre-edge pending state; the debounce below may re-arm it.
      if (commit) begin
         flag_d         = pend_flag_q;
         pending_d      = 1'b0;
         frames_since_d = 4'd0;
         changed_d      = 1'b1;
      end

      if (flag_valid) begin
         if (flag_in == cand_q) begin
            if (stable_cnt_q < 4'(STABLE_COUNT)) begin
               stable_cnt_d = stable_cnt_q + 4'd1;
            end
         end else begin
            cand_d       = flag_in;
            stable_cnt_d = 4'd1;
         end
      end

      qualified = flag_valid && (stable_cnt_d == 4'(STABLE_COUNT));

      // Comparing against the new flag lets a same-cycle commit absorb the request.
      if (qualified) begin
         if (cand_d != flag_d) begin
            pend_flag_d = cand_d;
            pending_d   = 1'b1;
         end else begin
            pending_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         flag_q         <= DEFAULT_FLAG;
         cand_q         <= DEFAULT_FLAG;
         stable_cnt_q   <= 4'd0;
         pend_flag_q    <= DEFAULT_FLAG;
         pending_q      <= 1'b0;
         frames_since_q <= 4'(HOLD_FRAMES);
         changed_q      <= 1'b0;
      end else begin
         flag_q         <= flag_d;
         cand_q         <= cand_d;
         stable_cnt_q   <= stable_cnt_d;
         pend_flag_q    <= pend_flag_d;
         pending_q      <= pending_d;
         frames_since_q <= frames_since_d;
         changed_q      <= changed_d;
      end
   end

   assign flag_out     = flag_q;
   assign flag_changed = changed_q;
   assign pending      = pending_q;

endmodule

// File: tb/tb_frame_sync_flag.sv
// Directed and randomized checks of frame_sync_flag against a behavioural
// model based on run lengths and frame counts.
module tb_frame_sync_flag;

   localparam int         STABLE = 4;
   localparam int         HOLD   = 2;
   localparam logic [1:0] DEF    = 2'd0;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] flag_in;
   logic       flag_valid;
   logic       valid_in;
   logic       ready_in;
   logic       eop_in;
   logic [1:0] flag_out;
   logic       flag_changed;
   logic       pending;

   int checkCount = 0;
   int passCount  = 0;

   // Reference state
   int mFlag, mLast, mRun, mPendVal, mFrames;
   bit mPend, mChg;

   frame_sync_flag #(
      .STABLE_COUNT(STABLE),
      .HOLD_FRAMES (HOLD),
      .DEFAULT_FLAG(DEF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flag_in     (flag_in),
      .flag_valid  (flag_valid),
      .valid_in    (valid_in),
      .ready_in    (ready_in),
      .eop_in      (eop_in),
      .flag_out    (flag_out),
      .flag_changed(flag_changed),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // One clock of the reference model using the values driven for this edge.
   task automatic modelStep(input bit rstN, input bit fv, input int fin,
                            input bit v, input bit r, input bit e);
      int newFlag;
      if (!rstN) begin
         mFlag = DEF; mLast = DEF; mRun = 0; mPendVal = DEF;
         mPend = 0; mFrames = HOLD; mChg = 0;
      end else begin
         newFlag = mFlag;
         mChg = 0;
         if (v && r && e) begin
            if (mPend && (mFrames + 1 >= HOLD)) begin
               newFlag = mPendVal;
               mPend = 0;
               mFrames = 0;
               mChg = 1;
            end else begin
               mFrames = (mFrames + 1 > 15) ? 15 : mFrames + 1;
            end
         end
         if (fv) begin
            if (fin == mLast) mRun++;
            else begin
               mLast = fin;
               mRun = 1;
            end
            if (mRun >= STABLE) begin
               if (mLast != newFlag) begin
                  mPendVal = mLast;
                  mPend = 1;
               end else begin
                  mPend = 0;
               end
            end
         end
         mFlag = newFlag;
      end
   endtask

   task automatic applyStimulus(input bit rstN, input bit fv, input int fin,
                                input bit v, input bit r, input bit e);
      reset      = rstN;
      flag_valid = fv;
      flag_in    = 2'(fin);
      valid_in   = v;
      ready_in   = r;
      eop_in     = e;
      @(posedge clk);
      modelStep(rstN, fv, fin, v, r, e);
      #1;
      checkOutput("flag_out", int'(flag_out), mFlag);
      checkOutput("flag_changed", int'(flag_changed), int'(mChg));
      checkOutput("pending", int'(pending), int'(mPend));
   endtask

   task automatic idle();            applyStimulus(1, 0, 0, 0, 0, 0); endtask
   task automatic strobe(input int f); applyStimulus(1, 1, f, 1, 1, 0); endtask
   task automatic frame();           applyStimulus(1, 0, 0, 1, 1, 1); endtask
   task automatic doReset();
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      doReset();
      checkOutput("reset_flag", int'(flag_out), int'(DEF));
      checkOutput("reset_pending", int'(pending), 0);

      // Frames with no strobes must never change the flag.
      for (int i = 0; i < 5; i++) begin
         idle();
         frame();
      end
      checkOutput("no_strobe_flag", int'(flag_out), 0);

      // Plain qualify and commit of flag 2.
      for (int i = 0; i < 4; i++) begin
         strobe(2);
         idle();
      end
      checkOutput("armed_after_4", int'(pending), 1);
      frame();
      checkOutput("commit_flag2", int'(flag_out), 2);
      checkOutput("commit_pulse", int'(flag_changed), 1);
      idle();
      checkOutput("pulse_one_cycle", int'(flag_changed), 0);

      // Interrupted run: the lone 3 restarts the candidate and is never committed.
      doReset();
      strobe(2); strobe(2); strobe(3); strobe(2); strobe(2); strobe(2);
      checkOutput("not_yet_armed", int'(pending), 0);
      strobe(2);
      checkOutput("armed_on_last", int'(pending), 1);
      frame();
      checkOutput("committed_2", int'(flag_out), 2);

      // Hold-off between commits.
      for (int i = 0; i < 4; i++) strobe(1);
      frame();
      frame();
      checkOutput("flag1_committed", int'(flag_out), 1);
      for (int i = 0; i < 4; i++) strobe(3);
      frame();
      checkOutput("held_off_flag", int'(flag_out), 1);
      checkOutput("held_off_pending", int'(pending), 1);
      idle();
      frame();
      checkOutput("after_hold_flag", int'(flag_out), 3);

      // Unhandshaked eop, then retraction to the current flag.
      idle(); idle(); frame(); frame();
      for (int i = 0; i < 4; i++) strobe(0);
      applyStimulus(1, 0, 0, 1, 0, 1);
      checkOutput("no_ready_no_commit", int'(flag_out), 3);
      for (int i = 0; i < 4; i++) strobe(3);
      checkOutput("retracted", int'(pending), 0);
      frame();
      checkOutput("no_pulse_retract", int'(flag_changed), 0);

      // Reset wins over a committing eop in the same cycle.
      for (int i = 0; i < 4; i++) strobe(1);
      frame(); frame();
      for (int i = 0; i < 4; i++) strobe(2);
      applyStimulus(0, 0, 0, 1, 1, 1);
      checkOutput("rst_vs_commit_flag", int'(flag_out), int'(DEF));
      checkOutput("rst_vs_commit_pulse", int'(flag_changed), 0);
      applyStimulus(1, 0, 0, 0, 0, 0);

      // Randomized traffic, including strobes coinciding with frame ends.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 199) != 0),
                       ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : (i / 40) % 4,
                       $urandom_range(0, 1),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 5) == 0));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
